mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 16-bit-address / 8-bit-data memory bus between NREQ requesters
//  (CPU fetch/load/store, DMA, video refresh). One access is in flight at a time.
//  Requesters are served round-robin. Memory has a fixed latency of WAIT_STATES cycles.
//  Sits between the requester ports and the system RAM/ROM decode.
// PARAMETERS
//  NREQ         4   number of requesters, 2..8
//  WAIT_STATES  0   extra memory cycles per access, 0..15
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  req        in   NREQ     req[i]: requester i wants an access
//  we         in   NREQ     we[i]: 1=write, 0=read
//  addr       in   NREQ*16  addr[i*16+:16]: requester i address
//  wdata      in   NREQ*8   wdata[i*8+:8]: requester i write data
//  lock       in   NREQ     lock[i]: hold bus for a multi-byte sequence (ARB_LOCK_EN only)
//  ack        out  NREQ     one-cycle completion pulse, one-hot
//  rdata      out  8        read data, valid in the ack cycle
//  busy       out  1        high while state != IDLE
//  mem_en     out  1        memory strobe
//  mem_we     out  1        memory write enable
//  mem_addr   out  16       memory address
//  mem_wdata  out  8        memory write data
//  mem_rdata  in   8        memory read data
// BEHAVIOUR
//  Reset values: ack=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   Internal reset: state=IDLE, last=NREQ-1, wcnt=0.
//  FSM has three states: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
//  IDLE: if any req is high, pick the first set req[i], scanning from last+1 upward with wrap.
//   Register gidx=i and last=i. Latch addr/we/wdata into the mem_* outputs.
//   Set mem_en=1 and mem_we=we[i]. Load wcnt=WAIT_STATES. Go to ACCESS.
//  ACCESS: mem_* outputs are held stable. If wcnt!=0, decrement wcnt.
//   Otherwise: capture rdata<=mem_rdata (reads only; on writes rdata keeps its old value).
//   Drop mem_en/mem_we, set ack[gidx]=1, and go to RESP.
//  RESP: ack is high for exactly this one cycle; clear it on exit. Always go to IDLE.
//   No arbitration happens in RESP.
//  Latency: ack is high WAIT_STATES+2 cycles after the IDLE cycle that samples req.
//   Peak throughput is one access per WAIT_STATES+3 cycles.
//  Protocol: a requester holds req/we/addr/wdata stable until it sees its ack.
//   It may re-assert req in the cycle after ack.
//   If req drops mid-access, the access still completes and ack still pulses.
//  Fairness: a requester that keeps req high is served at least once every NREQ grants.
//  Simultaneous requests: round-robin order only. There is no fixed priority except after
//   reset, where requester 0 wins first.
//  Reset mid-access: abort immediately. No ack is issued and mem_en drops on the next edge.
//   A partial write is permitted.
// CONFIGURATION
//  Macro ARB_LOCK_EN.
//  Defined: the lock port exists.
//   If lock[gidx]=1 in RESP, set owner=gidx and owned=1.
//   While owned, IDLE grants only the owner; other requesters wait.
//   owned clears in IDLE when lock[owner]=0.
//   This keeps the CPU's 3-byte opcode fetches atomic.
//  Undefined: the lock port is absent and round-robin is never suspended.
// STRUCTURE
//  Shared package cpu_bus_pkg holds:
//   - state enum ARB_IDLE/ARB_ACCESS/ARB_RESP
//   - widths BUS_AW=16, BUS_DW=8
//  One sub-module, rr_pick: combinational round-robin picker.
//   Inputs req and last; outputs grant index and valid.
//   Unit-testable on its own.
// TESTING
//  T1: WS=0, req[0] read addr 16'h1234, mem_rdata 8'hA5 -> mem_addr=1234 one cycle later;
//      ack[0] and rdata=A5 two cycles after req sampled.
//  T2: WS=3, req[1] write 16'h00FF<-8'h3C -> mem_we held for 4 cycles, ack[1] 5 cycles
//      after req, rdata unchanged.
//  T3: req=4'b1111 held after reset -> grants in order 0,1,2,3,0; each ack is one-hot and
//      one cycle wide.
//  T4: reset asserted in the second ACCESS cycle (WS=3) -> next cycle mem_en=0, busy=0,
//      no ack; after reset, requester 0 is granted first.
//  T5: ARB_LOCK_EN, lock[2]=1 with 3 reqs from requester 2 while req[0] is high ->
//      three consecutive grants to 2, then 0 is granted after lock[2] drops.
//  T6: req[3] dropped mid-ACCESS -> ack[3] still pulses once; no second access to 3.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared memory-bus definitions: arbiter state encoding and bus widths.
package cpu_bus_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req scanning upward from last+1 with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   grant,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit address / 8-bit data memory bus.
// Define ARB_LOCK_EN to add the lock port (bus ownership for multi-byte sequences).
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*BUS_AW-1:0] addr,
  input  logic [NREQ*BUS_DW-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]        lock,
`endif
  output logic [NREQ-1:0]        ack,
  output logic [BUS_DW-1:0]      rdata,
  output logic                   busy,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [BUS_AW-1:0]      mem_addr,
  output logic [BUS_DW-1:0]      mem_wdata,
  input  logic [BUS_DW-1:0]      mem_rdata
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        state, state_n;
  logic [IW-1:0]     gidx, gidx_n, last, last_n, pick;
  logic              pick_valid;
  logic [3:0]        wcnt, wcnt_n;
  logic [NREQ-1:0]   ack_n, req_eff;
  logic [BUS_DW-1:0] rdata_n, mem_wdata_n;
  logic [BUS_AW-1:0] mem_addr_n;
  logic              busy_n, mem_en_n, mem_we_n;

`ifdef ARB_LOCK_EN
  logic [IW-1:0] owner, owner_n;
  logic          owned, owned_n;

  // While the owner still holds lock, only the owner is visible to the picker.
  always_comb begin
    req_eff = req;
    if (owned && lock[owner])
      req_eff = req & ({{(NREQ-1){1'b0}}, 1'b1} << owner);
  end
`else
  assign req_eff = req;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_eff),
    .last  (last),
    .grant (pick),
    .valid (pick_valid)
  );

  always_comb begin
    state_n     = state;
    gidx_n      = gidx;
    last_n      = last;
    wcnt_n      = wcnt;
    ack_n       = '0;
    rdata_n     = rdata;
    mem_en_n    = mem_en;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
`ifdef ARB_LOCK_EN
    owner_n     = owner;
    owned_n     = owned;
`endif
    unique case (state)
      ARB_IDLE: begin
`ifdef ARB_LOCK_EN
        if (owned && !lock[owner]) owned_n = 1'b0;
`endif
        if (pick_valid) begin
          state_n     = ARB_ACCESS;
          gidx_n      = pick;
          last_n      = pick;
          mem_en_n    = 1'b1;
          mem_we_n    = we[pick];
          mem_addr_n  = addr[int'(pick)*BUS_AW +: BUS_AW];
          mem_wdata_n = wdata[int'(pick)*BUS_DW +: BUS_DW];
          wcnt_n      = 4'(WAIT_STATES);
        end
      end
      ARB_ACCESS: begin
        if (wcnt != 4'd0) begin
          wcnt_n = wcnt - 4'd1;
        end else begin
          if (!mem_we) rdata_n = mem_rdata;
          mem_en_n    = 1'b0;
          mem_we_n    = 1'b0;
          ack_n[gidx] = 1'b1;
          state_n     = ARB_RESP;
        end
      end
      ARB_RESP: begin
`ifdef ARB_LOCK_EN
        if (lock[gidx]) begin
          owner_n = gidx;
          owned_n = 1'b1;
        end
`endif
        state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
    busy_n = (state_n != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      gidx      <= '0;
      last      <= IW'(NREQ-1);
      wcnt      <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_LOCK_EN
      owner     <= '0;
      owned     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      gidx      <= gidx_n;
      last      <= last_n;
      wcnt      <= wcnt_n;
      ack       <= ack_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
`ifdef ARB_LOCK_EN
      owner     <= owner_n;
      owned     <= owned_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed steps plus randomized round-robin traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with zero wait states
  logic        reset0;
  logic [3:0]  req0, we0, lock0, ack0;
  logic [63:0] addr0;
  logic [31:0] wdata0;
  logic [7:0]  rdata0, mem_wdata0, mem_rdata0;
  logic        busy0, mem_en0, mem_we0;
  logic [15:0] mem_addr0;

  // Instance with three wait states
  logic        reset3;
  logic [3:0]  req3, we3, lock3, ack3;
  logic [63:0] addr3;
  logic [31:0] wdata3;
  logic [7:0]  rdata3, mem_wdata3, mem_rdata3;
  logic        busy3, mem_en3, mem_we3;
  logic [15:0] mem_addr3;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  assign mem_rdata0 = memf(mem_addr0);
  assign mem_rdata3 = memf(mem_addr3);

  mem_bus_arbiter #(.NREQ(4), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef ARB_LOCK_EN
    .lock(lock0),
`endif
    .ack(ack0), .rdata(rdata0), .busy(busy0), .mem_en(mem_en0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_bus_arbiter #(.NREQ(4), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset3), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
`ifdef ARB_LOCK_EN
    .lock(lock3),
`endif
    .ack(ack3), .rdata(rdata3), .busy(busy3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          last_m, idle_at, ack_due, gsel;
  logic [1:0]  j;
  logic [3:0]  cool;
  logic [7:0]  exp_rd;

  initial begin
    reset0 = 1'b1; req0 = '0; we0 = '0; lock0 = '0; addr0 = '0; wdata0 = '0;
    reset3 = 1'b1; req3 = '0; we3 = '0; lock3 = '0; addr3 = '0; wdata3 = '0;
    step(); step();
    check("rst_ack", ack0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_busy", busy0, 0);
    check("rst_mem_en", mem_en0, 0);
    check("rst_mem_we", mem_we0, 0);
    check("rst_mem_addr", mem_addr0, 0);
    check("rst_mem_wdata", mem_wdata0, 0);
    check("rst_ack3", ack3, 0);
    reset0 = 1'b0; reset3 = 1'b0;
    step();

    // T1: single read, zero wait states
    req0 = 4'b0001; we0 = 4'b0000; addr0[15:0] = 16'h1234;
    step();
    check("t1_mem_en", mem_en0, 1);
    check("t1_mem_addr", mem_addr0, 16'h1234);
    check("t1_mem_we", mem_we0, 0);
    check("t1_busy", busy0, 1);
    check("t1_ack_early", ack0, 0);
    step();
    check("t1_ack", ack0, 4'b0001);
    check("t1_rdata", rdata0, 8'hA5);
    check("t1_mem_en_off", mem_en0, 0);
    req0 = '0;
    step();
    check("t1_ack_clear", ack0, 0);
    check("t1_busy_idle", busy0, 0);

    // T3: all requesting after reset -> 0,1,2,3,0 every 3 cycles
    reset0 = 1'b1; step(); reset0 = 1'b0;
    req0 = 4'b1111; we0 = 4'b0000;
    for (int c = 1; c <= 14; c++) begin
      step();
      check("t3_ack", ack0, (c % 3 == 2) ? (32'd1 << ((c / 3) % 4)) : 32'd0);
    end
    req0 = '0;
    step();

    // T6: requester 3 drops req during its access
    req0 = 4'b1000; we0 = 4'b0000; addr0[63:48] = 16'hBEEF;
    step();
    check("t6_mem_addr", mem_addr0, 16'hBEEF);
    req0 = '0;
    step();
    check("t6_ack", ack0, 4'b1000);
    check("t6_rdata", rdata0, memf(16'hBEEF));
    for (int c = 0; c < 5; c++) begin
      step();
      check("t6_no_ack", ack0, 0);
      check("t6_no_access", mem_en0, 0);
    end
    exp_rd = memf(16'hBEEF);

    // Randomized traffic against a transaction-level round-robin model
    last_m = 3; idle_at = 0; ack_due = -1; gsel = 0;
    for (int c = 0; c < 300; c++) begin
      cool = '0;
      if (c == ack_due) begin
        check("rand_ack", ack0, 32'd1 << gsel);
        if (!we0[gsel]) exp_rd = memf(addr0[gsel*16 +: 16]);
        check("rand_rdata", rdata0, exp_rd);
        req0[gsel] = 1'b0;
        cool[gsel] = 1'b1;
      end else begin
        check("rand_no_ack", ack0, 0);
      end
      if (c == ack_due - 1) begin
        check("rand_mem_addr", mem_addr0, addr0[gsel*16 +: 16]);
        check("rand_mem_we", mem_we0, we0[gsel]);
        if (we0[gsel]) check("rand_mem_wdata", mem_wdata0, wdata0[gsel*8 +: 8]);
      end
      if (c < 240) begin
        for (int i = 0; i < 4; i++) begin
          if (!req0[i] && !cool[i] && $urandom_range(2) == 0) begin
            req0[i] = 1'b1;
            we0[i] = 1'($urandom);
            addr0[i*16 +: 16] = 16'($urandom);
            wdata0[i*8 +: 8] = 8'($urandom);
          end
        end
      end
      if (c >= idle_at && req0 != 4'b0) begin
        for (int off = 1; off <= 4; off++) begin
          j = 2'((last_m + off) % 4);
          if (req0[j]) begin
            gsel = int'(j);
            break;
          end
        end
        last_m = gsel; ack_due = c + 2; idle_at = c + 3;
      end
      step();
    end
    check("rand_drained", req0, 0);

`ifdef ARB_LOCK_EN
    // T5: requester 1 first so requester 2 is next in line, then lock
    step(); step();
    req0 = 4'b0010; we0 = '0; addr0[31:16] = 16'h0101;
    step(); step();
    check("t5_pre_ack", ack0, 4'b0010);
    req0 = '0;
    step();
    req0 = 4'b0101; lock0 = 4'b0100; we0 = '0;
    addr0[15:0] = 16'h0A00; addr0[47:32] = 16'h2000;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 2 || c == 5) addr0[47:32] = addr0[47:32] + 16'd1;
      if (c == 8) begin req0[2] = 1'b0; lock0 = '0; end
      check("t5_ack", ack0, (c == 2 || c == 5 || c == 8) ? 32'h4 : (c == 11) ? 32'h1 : 32'h0);
      if (c == 11) req0 = '0;
    end
`endif

    // T2: write with three wait states
    req3 = 4'b0010; we3 = 4'b0010; addr3[31:16] = 16'h00FF; wdata3[15:8] = 8'h3C;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("t2_mem_we", mem_we3, 1);
      check("t2_mem_en", mem_en3, 1);
      check("t2_mem_addr", mem_addr3, 16'h00FF);
      check("t2_mem_wdata", mem_wdata3, 8'h3C);
      check("t2_no_ack", ack3, 0);
    end
    step();
    check("t2_ack", ack3, 4'b0010);
    check("t2_rdata_kept", rdata3, 0);
    check("t2_mem_we_off", mem_we3, 0);
    req3 = '0; we3 = '0;
    step();

    // T4: reset in the second access cycle aborts; requester 0 wins afterwards
    req3 = 4'b0100; addr3[47:32] = 16'h4444;
    step();
    check("t4_access", mem_en3, 1);
    step();
    reset3 = 1'b1; req3 = 4'b1001; addr3[15:0] = 16'h1000; addr3[63:48] = 16'h3000;
    step();
    check("t4_mem_en", mem_en3, 0);
    check("t4_busy", busy3, 0);
    check("t4_ack", ack3, 0);
    reset3 = 1'b0;
    step();
    check("t4_regrant_addr", mem_addr3, 16'h1000);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("t4_ack_wait", ack3, (c == 4) ? 32'h1 : 32'h0);
    end
    req3 = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
